loctag_adc_reader: RTL and testbench

- Front-end stage directly upstream of the loctag detection core.
- Powers the LT5534 envelope detector and clocks a 16-bit-frame serial ADC (AD7476-class: 4 leading zeros followed by 12 data bits, MSB first).
- Delivers one 12-bit sample per frame with a valid strobe.
- Provides a hysteresis threshold comparator whose outputs feed the core's trigger and modulation logic.

---
 rtl/loctag_adc_pkg.sv | 20 ++
 rtl/loctag_hyst_cmp.sv | 44 ++++
 rtl/loctag_adc_reader.sv | 213 +++++++++++++++++++++
 tb/tb_loctag_adc_reader.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loctag_adc_pkg.sv
// Shared types and default frame geometry for the loctag ADC front-end.
package loctag_adc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        QUIET,
        SHIFT
    } adc_state_e;

    localparam int ADC_FRAME_BITS = 16;
    localparam int ADC_LEAD_ZEROS = 4;
    localparam int ADC_DATA_BITS  = ADC_FRAME_BITS - ADC_LEAD_ZEROS;

    // Width of a counter that runs 0..terminal-1, never narrower than one bit.
    function automatic int cnt_width(input int terminal);
        return (terminal > 1) ? $clog2(terminal) : 1;
    endfunction

endpackage

// File: rtl/loctag_hyst_cmp.sv
// Hysteresis threshold comparator with a one-cycle rise pulse; updates only on valid.
module loctag_hyst_cmp
#(
    parameter int DATA_BITS = 12,
    parameter int HYST      = 'h040
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid,
    input  logic [DATA_BITS-1:0] value,
    input  logic [DATA_BITS-1:0] threshold,
    output logic                 above,
    output logic                 rise
);

    localparam logic [DATA_BITS:0] HYST_EXT = (DATA_BITS + 1)'(HYST);

    logic set_hit;
    logic clr_hit;

    // One extra bit keeps value + HYST from wrapping, so a low threshold can never clear.
    always_comb begin
        set_hit = (value >= threshold);
        clr_hit = (({1'b0, value} + HYST_EXT) < {1'b0, threshold});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            above <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (valid) begin
                if (set_hit) begin
                    above <= 1'b1;
                    rise  <= ~above;
                end else if (clr_hit) begin
                    above <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/loctag_adc_reader.sv
// LT5534 power sequencing, AD7476-class serial ADC reader and hysteresis comparator.
// Optional LOCTAG_ADC_AVG_EN: output is the truncated mean of the last four raw samples.
module loctag_adc_reader
    import loctag_adc_pkg::*;
#(
    parameter int CLK_DIV       = 2,
    parameter int FRAME_BITS    = ADC_FRAME_BITS,
    parameter int DATA_BITS     = ADC_DATA_BITS,
    parameter int QUIET_CYCLES  = 3,
    parameter int WARMUP_CYCLES = 1000,
    parameter int HYST          = 'h040
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] threshold,
    output logic                 lt5534_en,
    output logic                 adc_cs,
    output logic                 adc_clk,
    input  logic                 adc_so,
    output logic [DATA_BITS-1:0] sample,
    output logic                 sample_valid,
    output logic                 above,
    output logic                 rise
);

    localparam int DIV_W   = cnt_width(CLK_DIV);
    localparam int BIT_W   = cnt_width(FRAME_BITS);
    localparam int QUIET_W = cnt_width(QUIET_CYCLES);
    localparam int WARM_W  = cnt_width(WARMUP_CYCLES);

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(FRAME_BITS - 1);
    localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_W'(QUIET_CYCLES - 1);
    localparam logic [WARM_W-1:0]  WARM_LAST  = WARM_W'(WARMUP_CYCLES - 1);

    adc_state_e           state_q, state_d;
    logic [WARM_W-1:0]    warm_cnt_q, warm_cnt_d;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [QUIET_W-1:0]   quiet_cnt_q, quiet_cnt_d;
    // Only the trailing DATA_BITS survive the shift; the leading zeros fall off the top.
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 lt_en_q, lt_en_d;
    logic                 cs_q, cs_d;
    logic                 sclk_q, sclk_d;
    logic [DATA_BITS-1:0] sample_q;
    logic                 valid_q;
    logic                 frame_done;
    logic [DATA_BITS-1:0] raw;
    logic [DATA_BITS-1:0] sample_next;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        warm_cnt_d  = warm_cnt_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        quiet_cnt_d = quiet_cnt_q;
        shreg_d     = shreg_q;
        lt_en_d     = lt_en_q;
        cs_d        = cs_q;
        sclk_d      = sclk_q;
        frame_done  = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d    = WARMUP;
                    lt_en_d    = 1'b1;
                    warm_cnt_d = '0;
                end
            end
            WARMUP: begin
                if (!enable) begin
                    state_d = IDLE;
                    lt_en_d = 1'b0;
                end else if (warm_cnt_q == WARM_LAST) begin
                    state_d   = SHIFT;
                    cs_d      = 1'b0;
                    sclk_d    = 1'b0;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                end else begin
                    warm_cnt_d = warm_cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (!sclk_q) begin
                        // Last low-phase cycle: data is stable, SCLK rises at this edge.
                        sclk_d  = 1'b1;
                        shreg_d = {shreg_q[DATA_BITS-2:0], adc_so};
                    end else if (bit_cnt_q == BIT_LAST) begin
                        state_d     = QUIET;
                        cs_d        = 1'b1;
                        quiet_cnt_d = '0;
                        frame_done  = 1'b1;
                    end else begin
                        sclk_d    = 1'b0;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            QUIET: begin
                if (quiet_cnt_q == QUIET_LAST) begin
                    if (enable) begin
                        state_d   = SHIFT;
                        cs_d      = 1'b0;
                        sclk_d    = 1'b0;
                        div_cnt_d = '0;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                        lt_en_d = 1'b0;
                    end
                end else begin
                    quiet_cnt_d = quiet_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            warm_cnt_q  <= '0;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            quiet_cnt_q <= '0;
            shreg_q     <= '0;
            lt_en_q     <= 1'b0;
            cs_q        <= 1'b1;
            sclk_q      <= 1'b1;
            sample_q    <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            warm_cnt_q  <= warm_cnt_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            quiet_cnt_q <= quiet_cnt_d;
            shreg_q     <= shreg_d;
            lt_en_q     <= lt_en_d;
            cs_q        <= cs_d;
            sclk_q      <= sclk_d;
            valid_q     <= frame_done;
            if (frame_done) begin
                sample_q <= sample_next;
            end
        end
    end

    assign raw = shreg_q;

`ifdef LOCTAG_ADC_AVG_EN
    localparam int SUM_W = DATA_BITS + 2;

    logic [DATA_BITS-1:0] hist_q [3];
    logic [SUM_W-1:0]     sum;
    logic                 warm_start;

    assign warm_start = (state_q == IDLE) && enable;

    always_comb begin
        sum         = SUM_W'(raw) + SUM_W'(hist_q[0]) + SUM_W'(hist_q[1]) + SUM_W'(hist_q[2]);
        sample_next = sum[SUM_W-1:2];
    end

    // NOTE: the history is reset explicitly, and cleared again on warm-up entry,
    // so no average ever mixes in samples from a previous run.
    always_ff @(posedge clk) begin
        if (reset || warm_start) begin
            for (int i = 0; i < 3; i++) begin
                hist_q[i] <= '0;
            end
        end else if (frame_done) begin
            hist_q[2] <= hist_q[1];
            hist_q[1] <= hist_q[0];
            hist_q[0] <= raw;
        end
    end
`else
    assign sample_next = raw;
`endif

    // Comparator evaluates the new sample at the same edge that loads it, so
    // above/rise line up with sample_valid.
    loctag_hyst_cmp #(
        .DATA_BITS (DATA_BITS),
        .HYST      (HYST)
    ) u_hyst_cmp (
        .clk       (clk),
        .reset     (reset),
        .valid     (frame_done),
        .value     (sample_next),
        .threshold (threshold),
        .above     (above),
        .rise      (rise)
    );

    assign lt5534_en    = lt_en_q;
    assign adc_cs       = cs_q;
    assign adc_clk      = sclk_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;

endmodule

// File: tb/tb_loctag_adc_reader.sv
// Scoreboard bench: an ADC model serves frame words, expectations are queued at frame start.
module tb_loctag_adc_reader;

    localparam int DATA_BITS = 12;
    localparam int HYST      = 'h040;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic [DATA_BITS-1:0] threshold;
    logic                 lt5534_en;
    logic                 adc_cs;
    logic                 adc_clk;
    logic                 adc_so;
    logic [DATA_BITS-1:0] sample;
    logic                 sample_valid;
    logic                 above;
    logic                 rise;

    typedef struct {
        logic [DATA_BITS-1:0] sample;
        logic                 above;
        logic                 rise;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] adc_words[$];
    logic [15:0] cur_word;
    int          bit_idx;

    logic [DATA_BITS-1:0] m_hist[3];
    logic                 m_above;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int valid_cnt = 0;
    int valid_cycs[$];
    int cs_fall_cyc = 0;
    int cs_rise_cyc = 0;
    int sclk_cnt = 0;
    int frame_rises = 0;
    int t_en;
    int t_rel;
    bit bad_cs, bad_clk, bad_en;

    loctag_adc_reader #(
        .WARMUP_CYCLES (10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .threshold    (threshold),
        .lt5534_en    (lt5534_en),
        .adc_cs       (adc_cs),
        .adc_clk      (adc_clk),
        .adc_so       (adc_so),
        .sample       (sample),
        .sample_valid (sample_valid),
        .above        (above),
        .rise         (rise)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_hist[i] = '0;
        m_above = 1'b0;
    endtask

    task automatic model_warm();
        for (int i = 0; i < 3; i++) m_hist[i] = '0;
    endtask

    task automatic push_expect(input logic [15:0] word);
        logic [DATA_BITS-1:0] raw;
        logic [DATA_BITS-1:0] s;
        logic [DATA_BITS+1:0] sum;
        logic                 set_hit, clr_hit, nxt;
        exp_t                 e;
        raw = word[DATA_BITS-1:0];
`ifdef LOCTAG_ADC_AVG_EN
        sum = 14'(raw) + 14'(m_hist[0]) + 14'(m_hist[1]) + 14'(m_hist[2]);
        s   = sum[13:2];
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = raw;
`else
        sum = '0;
        s   = raw;
`endif
        set_hit = (s >= threshold);
        clr_hit = ({1'b0, s} + 13'(HYST)) < {1'b0, threshold};
        nxt     = set_hit ? 1'b1 : (clr_hit ? 1'b0 : m_above);
        e.sample = s;
        e.above  = nxt;
        e.rise   = nxt & ~m_above;
        m_above  = nxt;
        exp_q.push_back(e);
    endtask

    // ADC model: first bit on CS fall, following bits after each SCLK rise.
    initial forever begin
        @(negedge adc_cs);
        cur_word = (adc_words.size() > 0) ? adc_words.pop_front() : 16'h0000;
        push_expect(cur_word);
        bit_idx = 0;
        adc_so  = cur_word[15];
    end

    initial forever begin
        @(posedge adc_clk);
        if (adc_cs === 1'b0 && bit_idx < 15) begin
            bit_idx++;
            adc_so = cur_word[15 - bit_idx];
        end
    end

    // Output monitor and scoreboard.
    initial begin
        logic prev_cs  = 1'b1;
        logic prev_clk = 1'b1;
        exp_t e;
        forever begin
            @(negedge clk);
            if (sample_valid === 1'b1) begin
                valid_cnt++;
                valid_cycs.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("sample[%0d]", valid_cnt), sample, e.sample);
                    check($sformatf("above[%0d]", valid_cnt), above, e.above);
                    check($sformatf("rise[%0d]", valid_cnt), rise, e.rise);
                end
            end else if (rise !== 1'b0 && reset === 1'b0) begin
                check("rise_without_valid", rise, 0);
            end
            if (prev_cs === 1'b1 && adc_cs === 1'b0) begin
                cs_fall_cyc = cyc;
                sclk_cnt    = 0;
            end
            if (adc_cs === 1'b0 && prev_clk === 1'b0 && adc_clk === 1'b1) sclk_cnt++;
            if (prev_cs === 1'b0 && adc_cs === 1'b1) begin
                cs_rise_cyc = cyc;
                frame_rises = sclk_cnt;
            end
            prev_cs  = adc_cs;
            prev_clk = adc_clk;
        end
    end

    task automatic wait_cs(input logic level, input int bound, input string tag);
        int n = 0;
        while (adc_cs !== level && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(tag, adc_cs, level);
    endtask

    task automatic wait_valids(input int target, input int bound, input string tag);
        int n = 0;
        while (valid_cnt < target && n < bound) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, valid_cnt, target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        threshold = 12'h800;
        adc_so    = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_lt5534_en", lt5534_en, 0);
        check("rst_adc_cs", adc_cs, 1);
        check("rst_adc_clk", adc_clk, 1);
        check("rst_sample", sample, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_above", above, 0);
        check("rst_rise", rise, 0);

        // Released but not enabled: the interface must stay parked.
        reset  = 1'b0;
        bad_cs = 0; bad_clk = 0; bad_en = 0;
        repeat (200) begin
            @(negedge clk);
            if (adc_cs !== 1'b1)    bad_cs  = 1;
            if (adc_clk !== 1'b1)   bad_clk = 1;
            if (lt5534_en !== 1'b0) bad_en  = 1;
        end
        check("idle_cs_high", bad_cs, 0);
        check("idle_sclk_high", bad_clk, 0);
        check("idle_detector_off", bad_en, 0);
        check("idle_no_valid", valid_cnt, 0);

        // Warm-up timing, frame shape, then the comparator sequence.
        adc_words = {16'h0ABC, 16'hF123, 16'h07FF, 16'h0800, 16'h07D0, 16'h07BF, 16'h0800};
        model_warm();
        enable = 1'b1;
        t_en   = cyc;
        check("en_before_edge", lt5534_en, 0);
        @(negedge clk);
        check("en_after_edge", lt5534_en, 1);
        wait_cs(1'b0, 50, "cs_fall_seen");
        check("cs_fall_delay", cyc - t_en, 11);
        wait_cs(1'b1, 100, "cs_rise_seen");
        repeat (2) @(negedge clk);
        check("cs_low_cycles", cs_rise_cyc - cs_fall_cyc, 64);
        check("sclk_rises", frame_rises, 16);

        // Drop enable during bit 5 of the seventh frame.
        wait_valids(6, 7 * 67 + 50, "six_valids");
        wait_cs(1'b0, 20, "frame7_start");
        repeat (21) @(negedge clk);
        enable = 1'b0;
        wait_valids(7, 100, "final_valid");
        check("frame_period_a", valid_cycs[1] - valid_cycs[0], 67);
        check("frame_period_b", valid_cycs[6] - valid_cycs[5], 67);
        repeat (5) @(negedge clk);
        check("stop_detector_off", lt5534_en, 0);
        bad_cs = 0;
        repeat (60) begin
            @(negedge clk);
            if (adc_cs !== 1'b1) bad_cs = 1;
        end
        check("stop_cs_high", bad_cs, 0);
        check("stop_valid_count", valid_cnt, 7);
        check("stop_scoreboard_empty", exp_q.size(), 0);

        // Reset during bit 9, then recovery through a full warm-up.
        threshold = 12'h030;
        adc_words = {16'h0555, 16'h0064, 16'h00C8, 16'h012C, 16'h0190};
        model_warm();
        enable = 1'b1;
        wait_cs(1'b0, 50, "abort_frame_start");
        repeat (37) @(negedge clk);
        reset = 1'b1;
        void'(exp_q.pop_back());
        model_reset();
        @(negedge clk);
        check("abort_cs", adc_cs, 1);
        check("abort_sclk", adc_clk, 1);
        check("abort_sample", sample, 0);
        check("abort_valid", sample_valid, 0);
        check("abort_detector_off", lt5534_en, 0);
        check("abort_above", above, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        t_rel = cyc;
        wait_cs(1'b0, 50, "restart_cs_fall");
        check("restart_delay", cyc - t_rel, 11);
        wait_valids(10, 4 * 67 + 50, "restart_three_valids");
        wait_cs(1'b0, 20, "restart_frame4");
        repeat (5) @(negedge clk);
        enable = 1'b0;
        wait_valids(11, 100, "restart_last_valid");
        repeat (100) @(negedge clk);
        check("end_valid_count", valid_cnt, 11);
        check("end_scoreboard_empty", exp_q.size(), 0);
        check("end_detector_off", lt5534_en, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
